// File: rtl/emu_scan_ctrl.sv
// ============================================================================
//  Module      : emu_scan_ctrl
//  Description : Checkpoint sequencer for the emulated DUT's scan chains.
//                A host save/load command pauses the DUT clocks, then shifts
//                the FF chain followed by the RAM chain, one word per
//                transfer. Save streams words out and loops the FF chain
//                back onto itself, so DUT state is left intact. Load streams
//                host words into the chains.
//
//  Ports       : clk, rst              - host clock, sync active-high reset
//                host_pause / pause    - host run/pause request, DUT pause
//                                        (clock gate: EN = !pause || se)
//                cmd_valid/ready/load  - command handshake (0 save, 1 load)
//                done                  - one-cycle completion pulse
//                in_valid/ready/data   - load stream from host
//                out_valid/ready/data  - save stream to host
//                emu_ff_se/di/do       - FF scan chain
//                emu_ram_se/sd/di/do   - RAM scan chain (sd = 1 for load)
//
//  Build option: EMU_SCAN_CTRL_RAM_EN
//                defined   - FF phase is followed by a RAM phase
//                undefined - FF phase goes straight to DONE; RAM scan
//                            outputs are tied low and emu_ram_do is ignored
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emu_scan_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int FF_WORDS   = 16,
    parameter int RAM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  host_pause,
    output logic                  pause,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    output logic                  done,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,

    output logic                  emu_ff_se,
    output logic [DATA_WIDTH-1:0] emu_ff_di,
    input  logic [DATA_WIDTH-1:0] emu_ff_do,

    output logic                  emu_ram_se,
    output logic                  emu_ram_sd,
    output logic [DATA_WIDTH-1:0] emu_ram_di,
    input  logic [DATA_WIDTH-1:0] emu_ram_do
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_MAX_WORDS = (FF_WORDS > RAM_WORDS) ? FF_WORDS : RAM_WORDS;
    localparam int c_CNT_W     = $clog2(c_MAX_WORDS + 1);

    // Counter value at which the current transfer is the last of its phase.
    localparam logic [c_CNT_W-1:0] c_FF_LAST  = c_CNT_W'(FF_WORDS - 1);
`ifdef EMU_SCAN_CTRL_RAM_EN
    localparam logic [c_CNT_W-1:0] c_RAM_LAST = c_CNT_W'(RAM_WORDS - 1);
`endif

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETTLE = 3'd1;
    localparam logic [2:0] c_ST_FF     = 3'd2;
    localparam logic [2:0] c_ST_RAM    = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic               r_mode;     // latched cmd_load: 0 save, 1 load
    logic [c_CNT_W-1:0] r_cnt;      // words shifted in the current phase

    logic [2:0]         w_state_nx;
    logic               w_mode_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;

    // ------------------------------------------------------------------------
    // Phase decode and transfer qualification
    // ------------------------------------------------------------------------
    logic w_ff_phase;
    logic w_ram_phase;
    logic w_xfer_phase;
    logic w_xfer;

    assign w_ff_phase   = (r_state == c_ST_FF);
    assign w_ram_phase  = (r_state == c_ST_RAM);
    assign w_xfer_phase = w_ff_phase | w_ram_phase;

    // A transfer happens on any shift-phase cycle where the host side of the
    // active stream is able to move a word. A stalled cycle leaves SE low so
    // the chain holds and the counter does not advance.
    assign w_xfer = w_xfer_phase & (r_mode ? in_valid : out_ready);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_cnt_nx   = r_cnt;

        case (r_state)
            c_ST_IDLE: begin
                // cmd_ready is high throughout IDLE, so valid alone accepts.
                if (cmd_valid) begin
                    w_mode_nx  = cmd_load;
                    w_cnt_nx   = '0;
                    w_state_nx = c_ST_SETTLE;
                end
            end

            c_ST_SETTLE: begin
                // One cycle with pause high and SE low so the DUT clock gates
                // close before the first shift.
                w_state_nx = c_ST_FF;
            end

            c_ST_FF: begin
                if (w_xfer) begin
                    if (r_cnt == c_FF_LAST) begin
                        w_cnt_nx   = '0;
`ifdef EMU_SCAN_CTRL_RAM_EN
                        w_state_nx = c_ST_RAM;
`else
                        w_state_nx = c_ST_DONE;
`endif
                    end else begin
                        w_cnt_nx = r_cnt + c_CNT_W'(1);
                    end
                end
            end

            c_ST_RAM: begin
`ifdef EMU_SCAN_CTRL_RAM_EN
                if (w_xfer) begin
                    if (r_cnt == c_RAM_LAST) begin
                        w_cnt_nx   = '0;
                        w_state_nx = c_ST_DONE;
                    end else begin
                        w_cnt_nx = r_cnt + c_CNT_W'(1);
                    end
                end
`else
                // Unreachable without a RAM phase; recover to IDLE.
                w_cnt_nx   = '0;
                w_state_nx = c_ST_IDLE;
`endif
            end

            c_ST_DONE: begin
                w_state_nx = c_ST_IDLE;
            end

            default: begin
                w_cnt_nx   = '0;
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Control outputs: decodes of registered state
    // ------------------------------------------------------------------------
    // host_pause only passes through while idle; once a sequence starts the
    // DUT stays paused regardless of what the host does.
    assign pause     = (r_state != c_ST_IDLE) | host_pause;
    assign cmd_ready = (r_state == c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign out_valid = w_xfer_phase & ~r_mode;
    assign in_ready  = w_xfer_phase &  r_mode;

    // ------------------------------------------------------------------------
    // FF chain datapath
    // ------------------------------------------------------------------------
    // Save feeds the chain's own output back in, so after FF_WORDS shifts the
    // chain is rotated a full turn and holds its original contents.
    assign emu_ff_se = w_ff_phase & w_xfer;
    assign emu_ff_di = w_ff_phase ? (r_mode ? in_data : emu_ff_do)
                                  : {DATA_WIDTH{1'b0}};

    // ------------------------------------------------------------------------
    // RAM chain datapath and save stream mux
    // ------------------------------------------------------------------------
`ifdef EMU_SCAN_CTRL_RAM_EN
    assign emu_ram_se = w_ram_phase & w_xfer;
    assign emu_ram_sd = w_ram_phase & r_mode;
    assign emu_ram_di = w_ram_phase ? (r_mode ? in_data : emu_ram_do)
                                    : {DATA_WIDTH{1'b0}};

    always_comb begin
        out_data = {DATA_WIDTH{1'b0}};
        if (!r_mode) begin
            if (w_ff_phase) begin
                out_data = emu_ff_do;
            end else if (w_ram_phase) begin
                out_data = emu_ram_do;
            end
        end
    end
`else
    logic w_unused_ram;

    // RAM chain is not sequenced in this build; its read data is discarded.
    assign w_unused_ram = (^emu_ram_do) ^ w_ram_phase;

    assign emu_ram_se = 1'b0;
    assign emu_ram_sd = 1'b0;
    assign emu_ram_di = {DATA_WIDTH{1'b0}};

    always_comb begin
        out_data = {DATA_WIDTH{1'b0}};
        if (!r_mode && w_ff_phase) begin
            out_data = emu_ff_do;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_emu_scan_ctrl.sv
// ============================================================================
//  Module      : tb_emu_scan_ctrl
//  Description : Scoreboard bench for emu_scan_ctrl with a behavioural
//                4-word circular FF chain and 2-word RAM chain.
//                Build option EMU_SCAN_CTRL_RAM_EN selects expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_emu_scan_ctrl;

    localparam int DW = 64;

`ifdef EMU_SCAN_CTRL_RAM_EN
    localparam int N_OUT  = 6;
    localparam int D_SAVE = 8;
    localparam int D_TOG  = 14;
    localparam int D_LOAD = 11;
`else
    localparam int N_OUT  = 4;
    localparam int D_SAVE = 6;
    localparam int D_TOG  = 10;
    localparam int D_LOAD = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          host_pause;
    logic          pause;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_load;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          emu_ff_se;
    logic [DW-1:0] emu_ff_di;
    logic [DW-1:0] emu_ff_do;
    logic          emu_ram_se;
    logic          emu_ram_sd;
    logic [DW-1:0] emu_ram_di;
    logic [DW-1:0] emu_ram_do;

    emu_scan_ctrl #(
        .DATA_WIDTH (DW),
        .FF_WORDS   (4),
        .RAM_WORDS  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_pause (host_pause),
        .pause      (pause),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .emu_ff_se  (emu_ff_se),
        .emu_ff_di  (emu_ff_di),
        .emu_ff_do  (emu_ff_do),
        .emu_ram_se (emu_ram_se),
        .emu_ram_sd (emu_ram_sd),
        .emu_ram_di (emu_ram_di),
        .emu_ram_do (emu_ram_do)
    );

    always #5 clk = ~clk;

    // A0..A3, B0..B1 preload; C0..C3, D0..D1 load data
    logic [DW-1:0] save_words [6] = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
                                      64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3,
                                      64'hB0B0_0000_0000_00B0, 64'hB1B1_0000_0000_00B1};
    logic [DW-1:0] ld_words   [6] = '{64'hC0C0_1111_0000_00C0, 64'hC1C1_1111_0000_00C1,
                                      64'hC2C2_1111_0000_00C2, 64'hC3C3_1111_0000_00C3,
                                      64'hD0D0_1111_0000_00D0, 64'hD1D1_1111_0000_00D1};

    // ------------------------------------------------------------------------
    // Behavioural scan chains
    // ------------------------------------------------------------------------
    logic [DW-1:0] ff_chain  [4];
    logic [DW-1:0] ram_chain [2];
    logic          preload;

    assign emu_ff_do  = ff_chain[0];
    assign emu_ram_do = ram_chain[0];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4; i++) ff_chain[i] <= save_words[i];
            for (int i = 0; i < 2; i++) ram_chain[i] <= save_words[4 + i];
        end else begin
            if (emu_ff_se) begin
                for (int i = 0; i < 3; i++) ff_chain[i] <= ff_chain[i + 1];
                ff_chain[3] <= emu_ff_di;
            end
            if (emu_ram_se) begin
                ram_chain[0] <= ram_chain[1];
                ram_chain[1] <= emu_ram_di;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    int            ld_idx = 0;
    bit            busy = 1'b0;
    bit            mon_en = 1'b0;
    bit            cur_load = 1'b0;
    logic [DW-1:0] exp_q [$];
    int            exp_done_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge, pops the scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready", cmd_ready, !busy);
            if (busy) chk("pause_busy", pause, 1);
            else      chk("pause_idle", pause, host_pause);

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_evt("out_extra");
                else chk("out_data", out_data, exp_q.pop_front());
            end

            if (emu_ff_se || emu_ram_se)
                chk("se_handshake", (out_valid && out_ready) || (in_valid && in_ready), 1);
            if (emu_ram_se)
                chk("ram_sd", emu_ram_sd, cur_load);
`ifndef EMU_SCAN_CTRL_RAM_EN
            chk("ram_tied", {emu_ram_se, emu_ram_sd, |emu_ram_di}, 0);
`endif

            if (done) begin
                if (exp_done_q.size() == 0) fail_evt("done_extra");
                else chk("done_cycle", cyc, exp_done_q.pop_front());
                done_cnt++;
            end

            if (in_valid && in_ready) ld_idx++;

            if (rst || done) busy = 1'b0;
            else if (cmd_valid && cmd_ready) begin
                busy   = 1'b1;
                ld_idx = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic do_preload();
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    // Issues a command in the current cycle (T) and drives the streams until
    // done is seen or a reset at rst_off is applied.
    task automatic run_seq(input bit load, input bit toggle, input int cmd_off,
                           input int rst_off, input int done_off, input bit host_tog);
        int t0;
        int start_done;
        bit fin;
        t0         = cyc;
        start_done = done_cnt;
        fin        = 1'b0;
        cur_load   = load;
        cmd_load   = load;
        cmd_valid  = 1'b1;
        if (!load) for (int i = 0; i < N_OUT; i++) exp_q.push_back(save_words[i]);
        exp_done_q.push_back(t0 + done_off);
        for (int k = 1; k < 80 && !fin; k++) begin
            @(posedge clk); #1;
            cmd_valid = (k == cmd_off);
            if (k == cmd_off) chk("cmd_ignored_ready", cmd_ready, 0);
            out_ready = toggle ? ((k % 2) == 1) : 1'b1;
            in_valid  = load && ((k % 3) != 0);
            in_data   = load ? ld_words[(ld_idx > 5) ? 5 : ld_idx] : '0;
            rst       = (k == rst_off);
            if (host_tog) host_pause = k[0];
            if (done_cnt != start_done) begin
                fin = 1'b1;
                chk("idle_after_done", cmd_ready, 1);
            end
            if (rst_off >= 0 && k == rst_off + 1) begin
                fin = 1'b1;
                chk("rst_ff_se", emu_ff_se, 0);
                chk("rst_ram_se", emu_ram_se, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_done", done, 0);
                chk("rst_pause", pause, host_pause);
                exp_q.delete();
                exp_done_q.delete();
            end
        end
        if (!fin) fail_evt("timeout");
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rst       = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        host_pause = 1'b0;
        cmd_valid  = 1'b0;
        cmd_load   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        preload    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_ses", {emu_ff_se, emu_ram_se, emu_ram_sd}, 0);
        chk("reset_valid_ready", {out_valid, in_ready}, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_ff_di", emu_ff_di, 0);
        chk("reset_ram_di", emu_ram_di, 0);
        chk("reset_pause0", pause, 0);
        host_pause = 1'b1;
        #1;
        chk("reset_pause1", pause, 1);
        rst     = 1'b0;
        preload = 1'b0;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // Save, zero stall, host_pause toggling underneath
        run_seq(1'b0, 1'b0, -1, -1, D_SAVE, 1'b1);
        host_pause = 1'b0;
        for (int i = 0; i < 4; i++) chk("save_ff_intact", ff_chain[i], save_words[i]);

        // Save with out_ready toggling
        do_preload();
        run_seq(1'b0, 1'b1, -1, -1, D_TOG, 1'b0);
        for (int i = 0; i < 4; i++) chk("tog_ff_intact", ff_chain[i], save_words[i]);

        // Load with in_valid gaps
        do_preload();
        run_seq(1'b1, 1'b0, -1, -1, D_LOAD, 1'b0);
        for (int i = 0; i < 4; i++) chk("load_ff", ff_chain[i], ld_words[i]);
`ifdef EMU_SCAN_CTRL_RAM_EN
        for (int i = 0; i < 2; i++) chk("load_ram", ram_chain[i], ld_words[4 + i]);
`else
        for (int i = 0; i < 2; i++) chk("ram_untouched", ram_chain[i], save_words[4 + i]);
`endif

        // Command pulse mid-sequence is ignored
        do_preload();
        run_seq(1'b0, 1'b0, 3, -1, D_SAVE, 1'b0);

        // Reset mid-sequence, then a fresh save
        do_preload();
        host_pause = 1'b1;
        run_seq(1'b0, 1'b0, -1, 4, D_SAVE, 1'b0);
        host_pause = 1'b0;
        do_preload();
        run_seq(1'b0, 1'b0, -1, -1, D_SAVE, 1'b0);
        for (int i = 0; i < 4; i++) chk("post_rst_ff", ff_chain[i], save_words[i]);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_done_drained", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
